// File: rtl/eeprom_pkg.sv
// rtl/eeprom_pkg.sv - shared EEPROM page geometry, timing defaults, state encoding
package eeprom_pkg;

    localparam int         PAGE_BYTES = 64;
    localparam int         ADDR_WIDTH = 15;
    localparam int         TWR_CYCLES = 250000;
    localparam logic [7:0] PAD_BYTE   = 8'hFF;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_ISSUE,
        ST_GUARD,
        ST_BUSY,
        ST_TWR,
        ST_FULL
    } state_e;

    // Mirror a byte so bit 7 lands in bit 0 (MSB-first presentation on the bus)
    function automatic logic [7:0] reverse_byte(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/page_timer.sv
// rtl/page_timer.sv - loadable down-counter with zero flag for guard and write-time waits
module page_timer #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/page_assembler.sv
// rtl/page_assembler.sv - packs sampled bytes into EEPROM pages and sequences page writes (option: PAGE_ASM_MSB_FIRST_EN)
module page_assembler #(
    parameter int                    PAGE_BYTES   = eeprom_pkg::PAGE_BYTES,
    parameter int                    ADDR_WIDTH   = eeprom_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR   = '0,
    parameter int                    GUARD_CYCLES = 256,
    parameter int                    TWR_CYCLES   = eeprom_pkg::TWR_CYCLES,
    parameter bit                    WRAP         = 1'b0,
    parameter logic [7:0]            PAD_BYTE     = eeprom_pkg::PAD_BYTE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              sample_data,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    flush,
    output logic [PAGE_BYTES*8-1:0] write_data,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic                    enable,
    input  logic                    done,
    output logic                    mem_full,
    output logic [9:0]              pages_written
);

    import eeprom_pkg::*;

    localparam int CW   = $clog2(PAGE_BYTES + 1);
    localparam int TMAX = (GUARD_CYCLES > TWR_CYCLES) ? GUARD_CYCLES : TWR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_e                  state_q;
    logic [CW-1:0]           byte_cnt_q;
    logic [PAGE_BYTES*8-1:0] page_q, page_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     addr_next;
    logic                    sample_ready_q, enable_q, mem_full_q;
    logic [9:0]              pages_q;

    logic                    accept, flush_go;
    logic [CW-1:0]           cnt_after;
    logic [7:0]              store_byte;
    logic                    tmr_load, tmr_zero;
    logic [TW-1:0]           tmr_val;

    assign accept    = (state_q == ST_FILL) && sample_valid && sample_ready_q;
    assign cnt_after = byte_cnt_q + CW'(accept);
    // A same-cycle byte counts toward the page before padding starts
    assign flush_go  = (state_q == ST_FILL) && flush && (cnt_after != '0);
    assign addr_next = {1'b0, addr_q} + (ADDR_WIDTH+1)'(PAGE_BYTES);

`ifdef PAGE_ASM_MSB_FIRST_EN
    assign store_byte = reverse_byte(sample_data);
`else
    assign store_byte = sample_data;
`endif

    // Next page image: store the accepted byte, then pad the tail on flush
    always_comb begin
        page_d = page_q;
        for (int k = 0; k < PAGE_BYTES; k++) begin
            if (accept && (byte_cnt_q == CW'(k))) begin
                page_d[8*k +: 8] = store_byte;
            end else if (flush_go && (CW'(k) >= cnt_after)) begin
                page_d[8*k +: 8] = PAD_BYTE;
            end
        end
    end

    // One timer serves both waits: armed in ISSUE for the guard, on done for tWR
    assign tmr_load = (state_q == ST_ISSUE) || ((state_q == ST_BUSY) && done);
    assign tmr_val  = (state_q == ST_ISSUE) ? TW'(GUARD_CYCLES - 1) : TW'(TWR_CYCLES - 1);

    page_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Page sequencing FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_FILL;
            byte_cnt_q     <= '0;
            page_q         <= '0;
            addr_q         <= START_ADDR;
            sample_ready_q <= 1'b0;
            enable_q       <= 1'b0;
            mem_full_q     <= 1'b0;
            pages_q        <= '0;
        end else begin
            enable_q <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    sample_ready_q <= 1'b1;
                    page_q         <= page_d;
                    if (accept) begin
                        byte_cnt_q <= cnt_after;
                    end
                    if (flush_go || (cnt_after == CW'(PAGE_BYTES))) begin
                        state_q        <= ST_ISSUE;
                        sample_ready_q <= 1'b0;
                        enable_q       <= 1'b1;
                    end
                end
                ST_ISSUE: state_q <= ST_GUARD;
                ST_GUARD: if (tmr_zero) state_q <= ST_BUSY;
                ST_BUSY:  if (done) state_q <= ST_TWR;
                ST_TWR: begin
                    if (tmr_zero) begin
                        if (pages_q != 10'h3FF) begin
                            pages_q <= pages_q + 10'd1;
                        end
                        byte_cnt_q <= '0;
                        if (addr_next[ADDR_WIDTH] && !WRAP) begin
                            addr_q     <= addr_next[ADDR_WIDTH-1:0];
                            state_q    <= ST_FULL;
                            mem_full_q <= 1'b1;
                        end else begin
                            addr_q         <= addr_next[ADDR_WIDTH] ? START_ADDR
                                                                    : addr_next[ADDR_WIDTH-1:0];
                            state_q        <= ST_FILL;
                            sample_ready_q <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    sample_ready_q <= 1'b0;
                    mem_full_q     <= 1'b1;
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign sample_ready  = sample_ready_q;
    assign write_data    = page_q;
    assign address       = addr_q;
    assign enable        = enable_q;
    assign mem_full      = mem_full_q;
    assign pages_written = pages_q;

endmodule

// File: tb/tb_page_assembler.sv
// tb/tb_page_assembler.sv - directed bench for page_assembler (three instances: normal, full-stop, wrap)
module tb_page_assembler;

    localparam int G = 8;
    localparam int T = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   sample_data;
    logic         sample_valid, flush, done;

    logic         sample_ready_a, enable_a, mem_full_a;
    logic [511:0] write_data_a;
    logic [14:0]  address_a;
    logic [9:0]   pages_written_a;
    logic         sample_ready_b, enable_b, mem_full_b;
    logic [511:0] write_data_b;
    logic [14:0]  address_b;
    logic [9:0]   pages_written_b;
    logic         sample_ready_c, enable_c, mem_full_c;
    logic [511:0] write_data_c;
    logic [14:0]  address_c;
    logic [9:0]   pages_written_c;

    int errors = 0;
    int checks = 0;
    int en_a = 0, en_b = 0;

    always #5 clk = ~clk;

    page_assembler #(.GUARD_CYCLES(G), .TWR_CYCLES(T)) u_a (
        .clk(clk), .rst(rst), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready_a), .flush(flush), .write_data(write_data_a),
        .address(address_a), .enable(enable_a), .done(done), .mem_full(mem_full_a),
        .pages_written(pages_written_a));

    page_assembler #(.START_ADDR(15'h7FC0), .GUARD_CYCLES(G), .TWR_CYCLES(T), .WRAP(1'b0)) u_b (
        .clk(clk), .rst(rst), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready_b), .flush(flush), .write_data(write_data_b),
        .address(address_b), .enable(enable_b), .done(done), .mem_full(mem_full_b),
        .pages_written(pages_written_b));

    page_assembler #(.START_ADDR(15'h7FC0), .GUARD_CYCLES(G), .TWR_CYCLES(T), .WRAP(1'b1)) u_c (
        .clk(clk), .rst(rst), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready_c), .flush(flush), .write_data(write_data_c),
        .address(address_c), .enable(enable_c), .done(done), .mem_full(mem_full_c),
        .pages_written(pages_written_c));

    always @(posedge clk) begin
        en_a <= en_a + int'(enable_a);
        en_b <= en_b + int'(enable_b);
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] b);
        logic [7:0] r;
`ifdef PAGE_ASM_MSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
        r = b;
`endif
        return r;
    endfunction

    // Called on the ISSUE-cycle negedge; done stays high for 4 cycles of guard,
    // drops, and returns at G+100 cycles after enable. Returns cycles until ready rises.
    task automatic run_page(output int c);
        c = 0;
        while (sample_ready_a !== 1'b1 && c < 400) begin
            if (c == 4)       done = 1'b0;
            if (c == G + 100) done = 1'b1;
            @(negedge clk);
            c++;
        end
    endtask

    logic [511:0] exp_pg;
    logic [7:0]   hi_byte, a1_byte;
    int           c, e0;

    initial begin
        rst = 1'b0; sample_data = '0; sample_valid = 1'b0; flush = 1'b0; done = 1'b1;
`ifdef PAGE_ASM_MSB_FIRST_EN
        hi_byte = 8'hFC; a1_byte = 8'h85;
`else
        hi_byte = 8'h3F; a1_byte = 8'hA1;
`endif
        repeat (2) @(negedge clk);
        check("rst_ready",   sample_ready_a, 0);
        check("rst_wdata",   write_data_a, 0);
        check("rst_addr",    address_a, 0);
        check("rst_enable",  enable_a, 0);
        check("rst_full",    mem_full_a, 0);
        check("rst_pages",   pages_written_a, 0);
        check("rst_addr_b",  address_b, 15'h7FC0);

        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", sample_ready_a, 1);

        // Page 1: bytes 0x00..0x3F
        for (int i = 0; i < 64; i++) exp_pg[8*i +: 8] = exp_byte(8'(i));
        for (int i = 0; i < 64; i++) begin
            sample_data = 8'(i); sample_valid = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check("p1_enable",  enable_a, 1);
        check("p1_ready",   sample_ready_a, 0);
        check("p1_wdata",   write_data_a, exp_pg);
        check("p1_byte0",   write_data_a[7:0], 8'h00);
        check("p1_byte63",  write_data_a[511:504], hi_byte);
        check("p1_addr",    address_a, 15'h0000);
        e0 = en_a;
        run_page(c);
        check("p1_latency", c, G + 100 + T + 1);
        check("p1_pulses",  en_a - e0, 1);
        check("p1_pages",   pages_written_a, 1);
        check("p1_addr_nx", address_a, 15'h0040);
        check("p1_kept",    write_data_a, exp_pg);
        check("b_full",     mem_full_b, 1);
        check("b_ready",    sample_ready_b, 0);
        check("b_pages",    pages_written_b, 1);
        check("c_addr",     address_c, 15'h7FC0);
        check("c_ready",    sample_ready_c, 1);
        check("c_full",     mem_full_c, 0);

        // Page 2: five bytes then flush
        for (int i = 0; i < 64; i++) exp_pg[8*i +: 8] = (i < 5) ? exp_byte(8'hA1 + 8'(i)) : 8'hFF;
        for (int i = 0; i < 5; i++) begin
            sample_data = 8'hA1 + 8'(i); sample_valid = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("p2_enable",  enable_a, 1);
        check("p2_wdata",   write_data_a, exp_pg);
        check("p2_byte0",   write_data_a[7:0], a1_byte);
        check("p2_byte5",   write_data_a[47:40], 8'hFF);
        check("p2_addr",    address_a, 15'h0040);
        run_page(c);
        check("p2_latency", c, G + 100 + T + 1);
        check("p2_pages",   pages_written_a, 2);
        check("p2_addr_nx", address_a, 15'h0080);
        check("b_pulses",   en_b, 1);
        check("b_full2",    mem_full_b, 1);
        check("b_ready2",   sample_ready_b, 0);
        check("c_addr2",    address_c, 15'h7FC0);
        check("c_pages2",   pages_written_c, 2);

        // Flush with an empty page does nothing
        e0 = en_a;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (20) @(negedge clk);
        check("flush0_pulses", en_a - e0, 0);
        check("flush0_ready",  sample_ready_a, 1);

        // Page 3: flush together with the third byte
        for (int i = 0; i < 64; i++) exp_pg[8*i +: 8] = (i < 3) ? exp_byte(8'h10 + 8'(i)) : 8'hFF;
        for (int i = 0; i < 3; i++) begin
            sample_data = 8'h10 + 8'(i); sample_valid = 1'b1;
            flush = (i == 2);
            @(negedge clk);
        end
        sample_valid = 1'b0; flush = 1'b0;
        check("p3_enable", enable_a, 1);
        check("p3_wdata",  write_data_a, exp_pg);
        check("p3_addr",   address_a, 15'h0080);

        // Asynchronous reset while waiting in BUSY
        done = 1'b0;
        repeat (G + 5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_ready",  sample_ready_a, 0);
        check("arst_wdata",  write_data_a, 0);
        check("arst_addr",   address_a, 0);
        check("arst_enable", enable_a, 0);
        check("arst_pages",  pages_written_a, 0);
        check("arst_full_b", mem_full_b, 0);
        check("arst_addr_c", address_c, 15'h7FC0);
        @(negedge clk);
        rst = 1'b1; done = 1'b1;
        @(negedge clk);
        check("arst_resume", sample_ready_a, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
